// File: rtl/turn_scheduler.sv
// -----------------------------------------------------------------------------
// turn_scheduler
// Turn sequencing for a two-player artillery game (dog vs. cat). The active
// player holds the fire key to charge throw power, releases it to launch, and
// the result of the flight decides hit points and whose turn comes next.
//
// Optional feature macro: TURN_TIMEOUT_EN
//   When defined, an idle player forfeits the turn after TIMEOUT_FRAMES
//   frame ticks without pressing the fire key. When undefined, no counter
//   exists and IDLE waits indefinitely.
//
// Ports
//   clk          in   system clock, rising edge only
//   rst          in   synchronous active-high reset
//   frame_tick   in   one-clk pulse per video frame
//   space        in   fire key level (1 = held)
//   throw_done   in   one-clk pulse, projectile flight finished
//   hit          in   qualifies throw_done (1 = opponent struck)
//   dog_turn     out  dog is the active player
//   cat_turn     out  cat is the active player (always ~dog_turn)
//   power        out  current / latched throw power
//   throw_start  out  one-clk launch pulse
//   hp_dog       out  dog hit points
//   hp_cat       out  cat hit points
//   game_over    out  match finished
//   winner       out  0 = dog won, 1 = cat won (valid with game_over)
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | waiting for the active player to press the fire key
// AIM     | key held, power charging on each frame tick
// FLIGHT  | projectile in the air, waiting for throw_done
// RESOLVE | one cycle: apply the latched hit, pick next turn or finish
// OVER    | match finished, everything frozen until reset
// -----------------------------------------------------------------------------
module turn_scheduler #(
    parameter int HP_INIT        = 5,
    parameter int POWER_MAX      = 200,
    parameter int POWER_STEP     = 2,
    parameter int TIMEOUT_FRAMES = 600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       space,
    input  logic       throw_done,
    input  logic       hit,
    output logic       dog_turn,
    output logic       cat_turn,
    output logic [7:0] power,
    output logic       throw_start,
    output logic [2:0] hp_dog,
    output logic [2:0] hp_cat,
    output logic       game_over,
    output logic       winner
);

    typedef enum logic [2:0] {
        IDLE,
        AIM,
        FLIGHT,
        RESOLVE,
        OVER
    } state_t;

    state_t     state;
    logic       space_q;
    logic       edge_arm;
    logic       hit_q;
    logic       space_rise;
    logic       space_fall;
    logic [8:0] power_sum;
    logic [7:0] power_inc;
    logic [2:0] opp_hp;
    logic [2:0] opp_hp_dec;

`ifdef TURN_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_FRAMES + 1);
    logic [CNT_W-1:0] idle_cnt;
`endif

    // space_q resets to 0, so a key still held when reset drops would look
    // like a fresh press; edge_arm masks rising edges for that first cycle.
    assign space_rise = space & ~space_q & edge_arm;
    assign space_fall = ~space & space_q;

    // One extra bit so the saturation compare sees any overflow.
    assign power_sum  = {1'b0, power} + 9'(POWER_STEP);
    assign power_inc  = (power_sum >= 9'(POWER_MAX)) ? 8'(POWER_MAX) : power_sum[7:0];

    assign opp_hp     = dog_turn ? hp_cat : hp_dog;
    assign opp_hp_dec = (opp_hp == 3'd0) ? 3'd0 : opp_hp - 3'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            space_q     <= 1'b0;
            edge_arm    <= 1'b0;
            hit_q       <= 1'b0;
            dog_turn    <= 1'b1;
            cat_turn    <= 1'b0;
            power       <= 8'd0;
            throw_start <= 1'b0;
            hp_dog      <= 3'(HP_INIT);
            hp_cat      <= 3'(HP_INIT);
            game_over   <= 1'b0;
            winner      <= 1'b0;
`ifdef TURN_TIMEOUT_EN
            idle_cnt    <= '0;
`endif
        end else begin
            space_q     <= space;
            edge_arm    <= 1'b1;
            throw_start <= 1'b0;

            case (state)
                IDLE: begin
                    if (space_rise) begin
                        power <= 8'd0;
                        state <= AIM;
`ifdef TURN_TIMEOUT_EN
                        idle_cnt <= '0;
`endif
                    end
`ifdef TURN_TIMEOUT_EN
                    else if (frame_tick) begin
                        if (idle_cnt == CNT_W'(TIMEOUT_FRAMES - 1)) begin
                            dog_turn <= ~dog_turn;
                            cat_turn <= dog_turn;
                            idle_cnt <= '0;
                        end else begin
                            idle_cnt <= idle_cnt + 1'b1;
                        end
                    end
`endif
                end

                AIM: begin
                    // Release wins over a coincident frame tick: power freezes.
                    if (space_fall) begin
                        throw_start <= 1'b1;
                        state       <= FLIGHT;
                    end else if (frame_tick && space) begin
                        power <= power_inc;
                    end
                end

                FLIGHT: begin
                    if (throw_done) begin
                        hit_q <= hit;
                        state <= RESOLVE;
                    end
                end

                RESOLVE: begin
                    if (hit_q) begin
                        if (dog_turn) hp_cat <= opp_hp_dec;
                        else          hp_dog <= opp_hp_dec;
                    end
                    if (hit_q && opp_hp_dec == 3'd0) begin
                        game_over <= 1'b1;
                        winner    <= ~dog_turn;
                        state     <= OVER;
                    end else begin
                        dog_turn <= ~dog_turn;
                        cat_turn <= dog_turn;
                        power    <= 8'd0;
                        state    <= IDLE;
`ifdef TURN_TIMEOUT_EN
                        idle_cnt <= '0;
`endif
                    end
                end

                OVER: begin
                    state <= OVER;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_turn_scheduler.sv
// -----------------------------------------------------------------------------
// tb_turn_scheduler
// Directed-vector bench for turn_scheduler. Stimulus pushes expected values
// into two queues: the power expected at each throw_start pulse, and full
// output snapshots requested via chk_req. A negedge monitor pops and compares.
// Timeout expectations follow whether TURN_TIMEOUT_EN is defined.
// -----------------------------------------------------------------------------
module tb_turn_scheduler;

    typedef struct packed {
        logic       dog;
        logic       cat;
        logic [7:0] pwr;
        logic [2:0] hpd;
        logic [2:0] hpc;
        logic       go;
        logic       win;
        logic       ts;
    } snap_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       frame_tick = 1'b0;
    logic       space = 1'b0;
    logic       throw_done = 1'b0;
    logic       hit = 1'b0;
    logic       dog_turn;
    logic       cat_turn;
    logic [7:0] power;
    logic       throw_start;
    logic [2:0] hp_dog;
    logic [2:0] hp_cat;
    logic       game_over;
    logic       winner;

    logic       chk_req = 1'b0;
    logic       ts_prev = 1'b0;
    int         n_cmp = 0;
    int         n_bad = 0;

    logic [7:0] throw_q[$];
    snap_t      snap_q[$];

    turn_scheduler dut (
        .clk         (clk),
        .rst         (rst),
        .frame_tick  (frame_tick),
        .space       (space),
        .throw_done  (throw_done),
        .hit         (hit),
        .dog_turn    (dog_turn),
        .cat_turn    (cat_turn),
        .power       (power),
        .throw_start (throw_start),
        .hp_dog      (hp_dog),
        .hp_cat      (hp_cat),
        .game_over   (game_over),
        .winner      (winner)
    );

    always #5 clk = ~clk;

    // Monitor: compare whenever the DUT launches or a snapshot is requested.
    always @(negedge clk) begin
        if (throw_start) begin
            n_cmp++;
            if (throw_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_throw: throw_start=1 power=%0d, required no throw_start", power);
            end else begin
                logic [7:0] e;
                e = throw_q.pop_front();
                if (power !== e) begin
                    n_bad++;
                    $display("FAIL throw_power: got %0d, required %0d", power, e);
                end
            end
            if (ts_prev) begin
                n_bad++;
                $display("FAIL throw_width: throw_start high on consecutive cycles, required one-clk pulse");
            end
        end
        ts_prev = throw_start;

        if (chk_req) begin
            snap_t a;
            snap_t e;
            a = '{dog_turn, cat_turn, power, hp_dog, hp_cat, game_over, winner, throw_start};
            n_cmp++;
            if (snap_q.size() == 0) begin
                n_bad++;
                $display("FAIL snapshot_queue: check requested with no expectation");
            end else begin
                e = snap_q.pop_front();
                if (a !== e) begin
                    n_bad++;
                    $display("FAIL snapshot#%0d: got dog=%0d cat=%0d pwr=%0d hpd=%0d hpc=%0d go=%0d win=%0d ts=%0d, required dog=%0d cat=%0d pwr=%0d hpd=%0d hpc=%0d go=%0d win=%0d ts=%0d",
                             n_cmp, a.dog, a.cat, a.pwr, a.hpd, a.hpc, a.go, a.win, a.ts,
                             e.dog, e.cat, e.pwr, e.hpd, e.hpc, e.go, e.win, e.ts);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic frame();
        frame_tick = 1'b1;
        tick();
        frame_tick = 1'b0;
        tick();
    endtask

    task automatic snap(input logic d, input logic [7:0] p, input logic [2:0] hd,
                        input logic [2:0] hc, input logic go, input logic w);
        snap_q.push_back('{d, ~d, p, hd, hc, go, w, 1'b0});
        chk_req = 1'b1;
        #5;
        chk_req = 1'b0;
        tick();
    endtask

    // Full turn: press, charge, release, flight result, resolve.
    task automatic play(input int frames, input logic h, input logic [7:0] expp);
        space = 1'b1;
        tick();
        repeat (frames) frame();
        throw_q.push_back(expp);
        space = 1'b0;
        tick();
        tick();
        throw_done = 1'b1;
        hit = h;
        tick();
        throw_done = 1'b0;
        hit = 1'b0;
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic to_dog;

        // Reset with the fire key held; release must not be seen as a throw.
        rst = 1'b1;
        space = 1'b1;
        tick(); tick(); tick();
        snap(1, 0, 5, 5, 0, 0);
        rst = 1'b0;
        tick(); tick();
        snap(1, 0, 5, 5, 0, 0);
        space = 1'b0;
        tick(); tick();
        snap(1, 0, 5, 5, 0, 0);

        // Dog: 10 frames -> power 20, then hit -> hp_cat 4, cat's turn.
        space = 1'b1;
        tick();
        repeat (10) frame();
        throw_q.push_back(8'd20);
        space = 1'b0;
        tick();
        tick();
        snap(1, 20, 5, 5, 0, 0);
        throw_done = 1'b1; hit = 1'b1; tick();
        throw_done = 1'b0; hit = 1'b0; tick();
        snap(0, 0, 5, 4, 0, 0);

        // Cat: throw_done in IDLE and AIM ignored; frame tick on release ignored.
        throw_done = 1'b1; hit = 1'b1; tick();
        throw_done = 1'b0; hit = 1'b0;
        snap(0, 0, 5, 4, 0, 0);
        space = 1'b1;
        tick();
        frame();
        throw_done = 1'b1; hit = 1'b1; tick();
        throw_done = 1'b0; hit = 1'b0;
        frame();
        frame();
        throw_q.push_back(8'd6);
        space = 1'b0;
        frame_tick = 1'b1;
        tick();
        frame_tick = 1'b0;
        tick();
        throw_done = 1'b1; hit = 1'b0; tick();
        throw_done = 1'b0; tick();
        snap(1, 0, 5, 4, 0, 0);

        // Dog: saturation at 200 over 120 frames, then hit -> hp_cat 3.
        space = 1'b1;
        tick();
        repeat (50) frame();
        snap(1, 100, 5, 4, 0, 0);
        repeat (70) frame();
        snap(1, 200, 5, 4, 0, 0);
        throw_q.push_back(8'd200);
        space = 1'b0;
        tick();
        tick();
        throw_done = 1'b1; hit = 1'b1; tick();
        throw_done = 1'b0; hit = 1'b0; tick();
        snap(0, 0, 5, 3, 0, 0);

        // Cat releases before any frame -> power 0, miss.
        play(0, 1'b0, 8'd0);
        snap(1, 0, 5, 3, 0, 0);
        play(4, 1'b1, 8'd8);
        snap(0, 0, 5, 2, 0, 0);
        play(1, 1'b0, 8'd2);
        play(2, 1'b1, 8'd4);
        snap(0, 0, 5, 1, 0, 0);
        play(7, 1'b0, 8'd14);
        play(3, 1'b1, 8'd6);
        snap(1, 6, 5, 0, 1, 0);

        // OVER ignores every input.
        space = 1'b1;
        tick();
        repeat (3) frame();
        space = 1'b0;
        tick();
        throw_done = 1'b1; hit = 1'b1; tick();
        throw_done = 1'b0; hit = 1'b0; tick();
        snap(1, 6, 5, 0, 1, 0);

        // Reset, then abort mid-AIM.
        rst = 1'b1; tick();
        rst = 1'b0; tick();
        snap(1, 0, 5, 5, 0, 0);
        space = 1'b1;
        tick();
        repeat (5) frame();
        rst = 1'b1;
        space = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        snap(1, 0, 5, 5, 0, 0);

        // Abort mid-FLIGHT; late throw_done lands in IDLE and is ignored.
        space = 1'b1;
        tick();
        repeat (2) frame();
        throw_q.push_back(8'd4);
        space = 1'b0;
        tick();
        tick();
        rst = 1'b1; tick();
        rst = 1'b0;
        throw_done = 1'b1; hit = 1'b1; tick();
        throw_done = 1'b0; hit = 1'b0; tick();
        snap(1, 0, 5, 5, 0, 0);

        // Idle timeout.
        repeat (599) frame();
        snap(1, 0, 5, 5, 0, 0);
        frame();
`ifdef TURN_TIMEOUT_EN
        to_dog = 1'b0;
`else
        to_dog = 1'b1;
`endif
        snap(to_dog, 0, 5, 5, 0, 0);

        tick(); tick();
        n_cmp++;
        if (throw_q.size() != 0 || snap_q.size() != 0) begin
            n_bad++;
            $display("FAIL leftover_expectations: throws=%0d snapshots=%0d pending, required 0",
                     throw_q.size(), snap_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/turn_scheduler.md
TURN_SCHEDULER -- requirements
Module: turn_scheduler

Interface
REQ-001 Parameter HP_INIT, default 5: starting hit points per player.
REQ-002 Parameter POWER_MAX, default 200: throw power saturation value.
REQ-003 Parameter POWER_STEP, default 2: power increment per frame while aiming.
REQ-004 Parameter TIMEOUT_FRAMES, default 600: idle frames before a turn is forfeited (used only with TURN_TIMEOUT_EN).
REQ-005 clk  in  1  system clock; all logic SHALL be clocked on its rising edge only.
REQ-006 rst  in  1  reset; synchronous and active-high.
REQ-007 frame_tick  in  1  one-clk pulse per video frame.
REQ-008 space  in  1  fire key level; 1 = held.
REQ-009 throw_done  in  1  one-clk pulse; projectile flight finished.
REQ-010 hit  in  1  qualifies throw_done; 1 = opponent struck.
REQ-011 dog_turn  out  1  dog is the active player.
REQ-012 cat_turn  out  1  cat is the active player; SHALL always equal ~dog_turn.
REQ-013 power  out  8  current/latched throw power.
REQ-014 throw_start  out  1  one-clk pulse launching the projectile.
REQ-015 hp_dog, hp_cat  out  3 each  remaining hit points.
REQ-016 game_over  out  1  match finished.
REQ-017 winner  out  1  0 = dog won, 1 = cat won; valid only while game_over=1.

Function
REQ-018 The FSM SHALL have states IDLE, AIM, FLIGHT, RESOLVE, OVER; all outputs SHALL be registered.
REQ-019 The block SHALL detect space edges with one registered copy of space; edge outputs feed the FSM in the same cycle.
REQ-020 IDLE: a space rising edge SHALL clear power to 0 and enter AIM next cycle.
REQ-021 AIM: each frame_tick with space=1 SHALL add POWER_STEP to power, saturating at POWER_MAX (never wraps).
REQ-022 AIM: a space falling edge SHALL pulse throw_start for exactly one clk, freeze power, and enter FLIGHT; a frame_tick in that same cycle SHALL NOT increment power.
REQ-023 A release before any frame_tick SHALL still throw, with power=0.
REQ-024 FLIGHT: the block SHALL wait for throw_done, latch hit on that cycle, then enter RESOLVE; space SHALL be ignored.
REQ-025 throw_done and hit SHALL be ignored in every state except FLIGHT.
REQ-026 RESOLVE (exactly one cycle): on latched hit, the opponent's hp SHALL decrement by 1, saturating at 0.
REQ-027 RESOLVE: if the opponent's hp becomes 0, the block SHALL enter OVER, set game_over=1, and set winner to the active player; otherwise it SHALL toggle dog_turn/cat_turn, clear power, and enter IDLE.
REQ-028 OVER SHALL hold all outputs until rst; every input SHALL be ignored.
REQ-029 throw_start SHALL be asserted only on the AIM->FLIGHT transition.

Reset
REQ-030 On rst=1 at a clk edge, the block SHALL enter IDLE with dog_turn=1, cat_turn=0, power=0, throw_start=0, hp_dog=hp_cat=HP_INIT, game_over=0, winner=0, timeout counter=0, and the registered space copy=0.
REQ-031 rst asserted mid-AIM or mid-FLIGHT SHALL abort the turn with no throw_start and no hp change.
REQ-032 A space level of 1 during reset SHALL NOT be taken as a rising edge in the first cycle after reset.

Configuration
REQ-033 With macro TURN_TIMEOUT_EN defined, IDLE SHALL count frame_ticks; on reaching TIMEOUT_FRAMES, the turn SHALL pass to the opponent with no hp change and the counter SHALL clear.
REQ-034 The timeout counter SHALL clear on every IDLE entry and on every space rising edge.
REQ-035 With TURN_TIMEOUT_EN undefined, no counter logic SHALL be synthesised and IDLE SHALL wait indefinitely.

Verification
REQ-036 Reset, press space, 10 frame_ticks, release -> throw_start 1 clk, power=20, state FLIGHT.
REQ-037 Hold space for 120 frame_ticks -> power saturates at 200 and never exceeds it.
REQ-038 throw_done with hit=1 on dog's turn -> hp_cat 5->4, cat_turn=1, power=0 in IDLE.
REQ-039 Five successive dog hits (cat throws miss, hit=0) -> hp_cat=0, game_over=1, winner=0; subsequent space and throw_done inputs have no effect.
REQ-040 throw_done pulsed in IDLE and AIM, and rst asserted mid-FLIGHT -> no hp change; after reset, all outputs equal their reset values.
REQ-041 With TURN_TIMEOUT_EN defined, 600 frame_ticks idle -> dog_turn 1->0, hp unchanged; with it undefined -> no turn change.
